// File: rtl/alu_req_issuer.sv
// alu_req_issuer: queues ALU requests in a small FIFO and sequences them onto the ALU input pins,
// with optional split operand delivery and a minimum spacing between issue starts.
module alu_req_issuer #(
  parameter int WIDTH         = 8,
  parameter int DEPTH         = 4,
  parameter int ISSUE_SPACING = 3,
  parameter int GAP_MAX       = 14
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_mode,
  input  logic [3:0]               req_cmd,
  input  logic [WIDTH-1:0]         req_opa,
  input  logic [WIDTH-1:0]         req_opb,
  input  logic                     req_cin,
  input  logic [1:0]               req_ops,
  input  logic                     req_split,
  input  logic [3:0]               req_gap,
  output logic [1:0]               inp_valid,
  output logic                     mode,
  output logic [3:0]               cmd,
  output logic                     ce,
  output logic [WIDTH-1:0]         opa,
  output logic [WIDTH-1:0]         opb,
  output logic                     cin,
  output logic                     issue_done,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = $clog2(ISSUE_SPACING + 1);
  localparam int DW = 2 * WIDTH + 13;
  localparam logic [CW-1:0] FULL_C    = CW'(DEPTH);
  localparam logic [EW-1:0] SPACE_C   = EW'(ISSUE_SPACING);
  localparam logic [3:0]    GAP_MAX_C = 4'(GAP_MAX);

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_ISSUE_A, S_GAP, S_ISSUE_B, S_SPACE
  } state_t;

  logic [DW-1:0]    r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]    r_count;
  state_t           r_state, w_state_next;
  logic [EW-1:0]    r_elapsed;
  logic [3:0]       r_gap_left;
  logic [1:0]       r_iv, w_iv_next;
  logic             r_ce, r_done, r_mode, r_cin;
  logic [3:0]       r_cmd;
  logic [WIDTH-1:0] r_opa, r_opb;
  logic             w_push, w_pop, w_load, w_try;
  logic [DW-1:0]    w_head;
  logic             w_h_mode, w_h_cin, w_h_split;
  logic [3:0]       w_h_cmd, w_h_gap;
  logic [1:0]       w_h_ops;
  logic [WIDTH-1:0] w_h_opa, w_h_opb;

  assign req_ready = rst && (r_count < FULL_C);
  assign w_push    = req_valid && req_ready;
  assign w_head    = r_mem[r_rd_ptr];
  assign {w_h_mode, w_h_cmd, w_h_cin, w_h_ops, w_h_split, w_h_gap, w_h_opa, w_h_opb} = w_head;

  always_ff @(posedge clk) begin
    if (w_push)
      r_mem[r_wr_ptr] <= {req_mode, req_cmd, req_cin, req_ops, req_split, req_gap, req_opa, req_opb};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_next;
  end

  // ISSUE, ISSUE_B and SPACE share one exit rule: once spacing is met, start the next request.
  always_comb begin
    w_state_next = r_state;
    w_pop        = 1'b0;
    w_load       = 1'b0;
    w_try        = 1'b0;
    case (r_state)
      S_IDLE:    w_try = 1'b1;
      S_ISSUE_A: w_state_next = (r_gap_left == 4'd0) ? S_ISSUE_B : S_GAP;
      S_GAP:     if (r_gap_left <= 4'd1) w_state_next = S_ISSUE_B;
      default: begin
        if (r_elapsed >= SPACE_C) w_try = 1'b1;
        else                      w_state_next = S_SPACE;
      end
    endcase
    if (w_try) begin
      w_state_next = S_IDLE;
      if (r_count != '0) begin
        w_pop = 1'b1;
        if (w_h_ops != 2'b00) begin
          w_load       = 1'b1;
          w_state_next = (w_h_ops == 2'b11 && w_h_split) ? S_ISSUE_A : S_ISSUE;
        end
      end
    end
  end

  always_comb begin
    w_iv_next = 2'b00;
    case (w_state_next)
      S_ISSUE:   w_iv_next = w_h_ops;
      S_ISSUE_A: w_iv_next = 2'b01;
      S_ISSUE_B: w_iv_next = 2'b10;
      default:   w_iv_next = 2'b00;
    endcase
  end

  // Pin values are registered from the next state so they line up with r_state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_iv       <= 2'b00;
      r_ce       <= 1'b0;
      r_done     <= 1'b0;
      r_mode     <= 1'b0;
      r_cmd      <= 4'd0;
      r_opa      <= '0;
      r_opb      <= '0;
      r_cin      <= 1'b0;
      r_gap_left <= 4'd0;
      r_elapsed  <= SPACE_C;
    end else begin
      r_iv   <= w_iv_next;
      r_ce   <= (w_state_next != S_IDLE);
      r_done <= (w_state_next == S_ISSUE) || (w_state_next == S_ISSUE_B);
      if (w_load) begin
        r_mode     <= w_h_mode;
        r_cmd      <= w_h_cmd;
        r_opa      <= w_h_opa;
        r_opb      <= w_h_opb;
        r_cin      <= w_h_cin;
        r_gap_left <= (w_h_gap > GAP_MAX_C) ? GAP_MAX_C : w_h_gap;
        r_elapsed  <= EW'(1);
      end else begin
        if (r_elapsed < SPACE_C) r_elapsed <= r_elapsed + EW'(1);
        if (r_state == S_GAP)    r_gap_left <= r_gap_left - 4'd1;
      end
    end
  end

  assign inp_valid  = r_iv;
  assign ce         = r_ce;
  assign issue_done = r_done;
  assign mode       = r_mode;
  assign cmd        = r_cmd;
  assign opa        = r_opa;
  assign opb        = r_opb;
  assign cin        = r_cin;
  assign busy       = (r_state != S_IDLE);
  assign count      = r_count;
endmodule
